// File: rtl/rom_burst_rd_pkg.sv
// rom_burst_rd_pkg: shared definitions for the ROM burst read sequencer.
//   - Default widths for the ROM word, ROM address, burst length field and
//     output FIFO depth (log2).
//   - Sequencer state encodings.
package rom_burst_rd_pkg;

  localparam int ROM_BRD_WORD_W  = 32;
  localparam int ROM_BRD_ADDR_W  = 8;
  localparam int ROM_BRD_LEN_W   = 9;
  localparam int ROM_BRD_FIFO_AW = 2;

  typedef enum logic [1:0] {
    ROM_BRD_IDLE  = 2'd0,
    ROM_BRD_FETCH = 2'd1,
    ROM_BRD_DRAIN = 2'd2
  } rom_brd_state_e;

endpackage

// File: rtl/rom_burst_rd_fifo.sv
// rom_burst_rd_fifo: synchronous FIFO with register-array storage.
// Parameters:
//   WIDTH   entry width
//   AW      log2 of depth (AW >= 1)
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset (clears pointers/count)
//   push_i        write wdata_i (ignored when full unless popping same cycle)
//   wdata_i       write data
//   pop_i         remove head entry (ignored when empty)
//   rdata_o       head entry, meaningful only when empty_o = 0
//   count_o       number of stored entries (0 .. 2^AW)
//   full_o        count_o == 2^AW
//   empty_o       count_o == 0
module rom_burst_rd_fifo
  import rom_burst_rd_pkg::*;
#(
  parameter int WIDTH = ROM_BRD_WORD_W,
  parameter int AW    = ROM_BRD_FIFO_AW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [AW:0]      count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  // Count never exceeds DEPTH, so its MSB alone flags full.
  assign full_o  = count_q[AW];
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot, so push is legal even when full.
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is pure data: no reset needed, entries are only visible when valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/rom_burst_rd.sv
// rom_burst_rd: burst read sequencer in front of a single-port ROM with a
// one-cycle read latency. Takes (base, len) commands, issues ROM reads under
// a credit rule that guarantees FIFO space for every in-flight word, and
// streams the words out in order on a valid/ready interface.
// Optional feature: define ROM_BURST_RD_LAST_EN to add last_o, which marks
// the final word of a burst (carried as an extra FIFO bit).
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   start_i, base_addr_i,    burst command; accepted only while busy_o = 0
//   len_i
//   busy_o                   high from accepted start until done_o
//   done_o                   one-cycle pulse after the last word is popped
//   rom_cen_o, rom_oen_o,    ROM chip enable / output enable (low active), address
//   rom_addr_o
//   rom_data_i               ROM read data, valid one cycle after rom_cen_o low
//   data_o, valid_o, ready_i output word stream
//   last_o                   (ROM_BURST_RD_LAST_EN only) final word marker
module rom_burst_rd
  import rom_burst_rd_pkg::*;
#(
  parameter int WORD_WIDTH = ROM_BRD_WORD_W,
  parameter int ADDR_WIDTH = ROM_BRD_ADDR_W,
  parameter int LEN_WIDTH  = ROM_BRD_LEN_W,
  parameter int FIFO_AW    = ROM_BRD_FIFO_AW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  rom_cen_o,
  output logic                  rom_oen_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [WORD_WIDTH-1:0] rom_data_i,
  output logic [WORD_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i
`ifdef ROM_BURST_RD_LAST_EN
  ,
  output logic                  last_o
`endif
);

`ifdef ROM_BURST_RD_LAST_EN
  localparam int FW = WORD_WIDTH + 1;
`else
  localparam int FW = WORD_WIDTH;
`endif

  // DEPTH = 2^FIFO_AW, sized to hold count + inflight without overflow.
  localparam logic [FIFO_AW+1:0] DEPTH_L = {1'b0, 1'b1, {FIFO_AW{1'b0}}};

  rom_brd_state_e        state_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  inflight_q;
  logic                  done_q;
  logic [WORD_WIDTH-1:0] hold_q;
  logic [WORD_WIDTH-1:0] hold_d;

  logic                  issue;
  logic                  pop;
  logic                  last_pop;
  logic [FIFO_AW+1:0]    occupancy;
  logic [FW-1:0]         fifo_wdata;
  logic [FW-1:0]         fifo_rdata;
  logic [FIFO_AW:0]      fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;

  // Words already stored plus the one possibly still inside the ROM.
  assign occupancy = {1'b0, fifo_count} + {{(FIFO_AW+1){1'b0}}, inflight_q};
  assign issue     = (state_q == ROM_BRD_FETCH) && (rem_q != '0) && (occupancy < DEPTH_L);
  assign pop       = valid_o & ready_i;
  // In DRAIN every read has issued, so one stored word and nothing in
  // flight means this pop removes the final word of the burst.
  assign last_pop  = pop && (fifo_count == (FIFO_AW+1)'(1)) && !inflight_q;

  assign busy_o     = (state_q != ROM_BRD_IDLE);
  assign done_o     = done_q;
  assign rom_cen_o  = ~issue;
  assign rom_oen_o  = (state_q == ROM_BRD_IDLE);
  assign rom_addr_o = addr_q;
  assign valid_o    = ~fifo_empty;
  // When the FIFO runs dry the last popped word stays on data_o.
  assign data_o     = fifo_empty ? hold_q : fifo_rdata[WORD_WIDTH-1:0];
  assign hold_d     = pop ? fifo_rdata[WORD_WIDTH-1:0] : hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ROM_BRD_IDLE;
      rem_q      <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      inflight_q <= issue;
      case (state_q)
        ROM_BRD_IDLE: begin
          if (start_i) begin
            if (len_i == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= ROM_BRD_FETCH;
              rem_q   <= len_i;
              addr_q  <= base_addr_i;
            end
          end
        end
        ROM_BRD_FETCH: begin
          if (issue) begin
            rem_q  <= rem_q - LEN_WIDTH'(1);
            addr_q <= addr_q + ADDR_WIDTH'(1);
            if (rem_q == LEN_WIDTH'(1)) state_q <= ROM_BRD_DRAIN;
          end
        end
        ROM_BRD_DRAIN: begin
          if (last_pop) begin
            state_q <= ROM_BRD_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ROM_BRD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end

`ifdef ROM_BURST_RD_LAST_EN
  // Tags the in-flight read that carries the final word of the burst.
  logic inflight_last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight_last_q <= 1'b0;
    else        inflight_last_q <= issue && (rem_q == LEN_WIDTH'(1));
  end

  assign fifo_wdata = {inflight_last_q, rom_data_i};
  assign last_o     = valid_o & fifo_rdata[WORD_WIDTH];
`else
  assign fifo_wdata = rom_data_i;
`endif

  rom_burst_rd_fifo #(
    .WIDTH (FW),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_rom_burst_rd.sv
// Testbench for rom_burst_rd: ROM model, scoreboard queues filled at command
// time from a reference model (word i of a burst = mem[(base+i) mod 256]),
// and an independent monitor comparing every ROM address and output word.
`timescale 1ns/1ps
module tb_rom_burst_rd;

  localparam int WW = 32, AW = 8, LW = 9, DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [LW-1:0] len_i;
  logic          busy_o, done_o, rom_cen_o, rom_oen_o;
  logic [AW-1:0] rom_addr_o;
  logic [WW-1:0] rom_data_i;
  logic [WW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
`ifdef ROM_BURST_RD_LAST_EN
  logic          last_o;
`endif

  typedef struct {
    logic [WW-1:0] d;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] addr_exp[$];
  logic [WW-1:0] mem [256];

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  int issued = 0, popped = 0, done_cnt = 0;
  int start_cyc = 0, first_issue_cyc = -1, first_valid_cyc = -1, done_cyc = -1;
  int ready_mode = 1;  // 0: hold low, 1: hold high, 2: random

  rom_burst_rd dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .rom_cen_o   (rom_cen_o),
    .rom_oen_o   (rom_oen_o),
    .rom_addr_o  (rom_addr_o),
    .rom_data_i  (rom_data_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i)
`ifdef ROM_BURST_RD_LAST_EN
    ,
    .last_o      (last_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port ROM: registered read, one-cycle latency.
  always @(posedge clk) begin
    if (!rom_cen_o) rom_data_i <= mem[rom_addr_o];
  end

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       ready_i = 1'b0;
      1:       ready_i = 1'b1;
      default: ready_i = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got 0x%0h, expected no such event", name, act);
  endtask

  // Monitor: compares ROM addresses and output beats against the queues.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (!rom_cen_o) begin
        check("credit", 64'((issued - popped) < DEPTH), 64'd1);
        if (first_issue_cyc < 0) first_issue_cyc = cyc;
        if (addr_exp.size() == 0) fail_now("extra_read", 64'(rom_addr_o));
        else check("rom_addr", 64'(rom_addr_o), 64'(addr_exp.pop_front()));
        issued++;
      end
      if (valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          fail_now("extra_word", 64'(data_o));
        end else begin
          e = exp_q.pop_front();
          check("data", 64'(data_o), 64'(e.d));
`ifdef ROM_BURST_RD_LAST_EN
          check("last", 64'(last_o), 64'(e.last));
`endif
        end
        popped++;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_busy"},  64'(busy_o),     64'd0);
    check({tag, "_done"},  64'(done_o),     64'd0);
    check({tag, "_cen"},   64'(rom_cen_o),  64'd1);
    check({tag, "_oen"},   64'(rom_oen_o),  64'd1);
    check({tag, "_addr"},  64'(rom_addr_o), 64'd0);
    check({tag, "_valid"}, 64'(valid_o),    64'd0);
    check({tag, "_data"},  64'(data_o),     64'd0);
`ifdef ROM_BURST_RD_LAST_EN
    check({tag, "_last"},  64'(last_o),     64'd0);
`endif
  endtask

  // Called just after a clock edge; the next edge samples the command.
  task automatic start_burst(input int base, input int len);
    for (int i = 0; i < len; i++) begin
      exp_t e;
      e.d    = mem[8'(base + i)];
      e.last = (i == len - 1);
      exp_q.push_back(e);
      addr_exp.push_back(8'(base + i));
    end
    first_issue_cyc = -1;
    first_valid_cyc = -1;
    done_cyc        = -1;
    base_addr_i = AW'(base);
    len_i       = LW'(len);
    start_i     = 1'b1;
    start_cyc   = cyc;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic finish_burst(input int iss0, input int d0, input int len);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 40 + len * 10) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == d0) fail_now("done_timeout", 64'(n));
    repeat (2) @(posedge clk);
    #1;
    check("done_pulses", 64'(done_cnt - d0),    64'd1);
    check("read_count",  64'(issued - iss0),    64'(len));
    check("words_left",  64'(exp_q.size()),     64'd0);
    check("busy_after",  64'(busy_o),           64'd0);
    exp_q.delete();
    addr_exp.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int iss0, d0, p0, base, len;
    rst_n = 1'b0;
    start_i = 1'b0;
    base_addr_i = '0;
    len_i = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'(i * 3);
    repeat (3) @(posedge clk);
    #1;
    check_reset("init");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: basic burst, latency and throughput
    ready_mode = 1;
    @(posedge clk); #1;
    iss0 = issued; d0 = done_cnt;
    start_burst(32'h10, 4);
    check("t1_busy", 64'(busy_o), 64'd1);
    check("t1_oen",  64'(rom_oen_o), 64'd0);
    finish_burst(iss0, d0, 4);
    check("t1_issue_lat", 64'(first_issue_cyc - start_cyc), 64'd1);
    check("t1_valid_lat", 64'(first_valid_cyc - start_cyc), 64'd3);
    check("t1_done_lat",  64'(done_cyc - start_cyc),        64'd7);

    // 2: zero-length command
    iss0 = issued; d0 = done_cnt;
    start_burst(32'h20, 0);
    @(negedge clk);
    check("t2_done", 64'(done_o), 64'd1);
    check("t2_busy", 64'(busy_o), 64'd0);
    @(negedge clk);
    check("t2_done_off", 64'(done_o), 64'd0);
    check("t2_no_read",  64'(issued - iss0), 64'd0);
    check("t2_one_done", 64'(done_cnt - d0), 64'd1);
    @(posedge clk); #1;

    // 3: address wrap
    iss0 = issued; d0 = done_cnt;
    start_burst(32'hFE, 4);
    finish_burst(iss0, d0, 4);

    // 4: backpressure stall at FIFO depth
    ready_mode = 0;
    @(posedge clk); #1;
    iss0 = issued; d0 = done_cnt; p0 = popped;
    start_burst(0, 8);
    repeat (9) @(posedge clk);
    #1;
    check("t4_stall_reads", 64'(issued - iss0), 64'd4);
    check("t4_no_pops",     64'(popped - p0),   64'd0);
    check("t4_cen_high",    64'(rom_cen_o),     64'd1);
    check("t4_valid",       64'(valid_o),       64'd1);
    check("t4_busy",        64'(busy_o),        64'd1);
    ready_mode = 1;
    finish_burst(iss0, d0, 8);

    // 5: reset in the middle of a burst
    d0 = done_cnt;
    start_burst(0, 16);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset("t5_rst");
    exp_q.delete();
    addr_exp.delete();
    issued = 0;
    popped = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_done", 64'(done_cnt - d0), 64'd0);
    iss0 = issued; d0 = done_cnt;
    start_burst(0, 2);
    finish_burst(iss0, d0, 2);

    // 6: last marker and start while busy
    ready_mode = 2;
    iss0 = issued; d0 = done_cnt;
    start_burst(32'h40, 3);
    start_i = 1'b1; base_addr_i = 8'h80; len_i = 9'd5;
    @(posedge clk); #1;
    start_i = 1'b0;
    finish_burst(iss0, d0, 3);

    // Randomized bursts
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int k = 0; k < 30; k++) begin
      ready_mode = $urandom_range(1, 2);
      base = $urandom_range(0, 255);
      len  = (k == 29) ? 256 : $urandom_range(0, 24);
      iss0 = issued; d0 = done_cnt;
      start_burst(base, len);
      if (len > 2 && $urandom_range(0, 1) == 1) begin
        start_i = 1'b1; base_addr_i = AW'($urandom_range(0, 255)); len_i = 9'd7;
        @(posedge clk); #1;
        start_i = 1'b0;
      end
      finish_burst(iss0, d0, len);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_burst_rd.md
Name: rom_burst_rd

Overview:
Read sequencer that sits directly upstream of the single-port ROM model (rom_1p) and consumes its output.
- Accepts a burst command (base address, length) and drives the ROM chip-enable, output-enable and address pins.
- Absorbs the ROM's one-cycle read latency and returns words in order on a valid/ready stream.
- Used by encoder stages to fetch coefficient, scan-order and context tables.

Parameters:
- WORD_WIDTH, 32, ROM word width; must match the ROM.
- ADDR_WIDTH, 8, ROM address width; must match the ROM.
- LEN_WIDTH, 9, burst length field width; maximum length is 2^ADDR_WIDTH.
- FIFO_AW, 2, log2 of the output FIFO depth (default depth 4; minimum depth 2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  burst command strobe; accepted only when busy_o=0.
- base_addr_i  in  ADDR_WIDTH  first ROM address; sampled with start_i.
- len_i  in  LEN_WIDTH  number of words; sampled with start_i.
- busy_o  out  1  high from the accepted start until done_o.
- done_o  out  1  one-cycle pulse when the burst completes.
- rom_cen_o  out  1  ROM chip enable, low active.
- rom_oen_o  out  1  ROM output enable, low active.
- rom_addr_o  out  ADDR_WIDTH  ROM address.
- rom_data_i  in  WORD_WIDTH  ROM read data, valid one cycle after rom_cen_o is low.
- data_o  out  WORD_WIDTH  output word.
- valid_o  out  1  data_o is valid.
- ready_i  in  1  downstream accepts data_o.

Behaviour:
- Reset values: busy_o=0, done_o=0, rom_cen_o=1, rom_oen_o=1, rom_addr_o=0, valid_o=0, data_o=0. Reset clears the FIFO, counters and in-flight flag.
- Reset mid-burst aborts the burst immediately. No done_o pulse is produced for the aborted burst.
- State machine: IDLE, FETCH, DRAIN.
  - IDLE -> FETCH on start_i with len_i != 0.
  - IDLE on start_i with len_i == 0: stay in IDLE, pulse done_o in the next cycle, issue no read.
  - FETCH -> DRAIN when the last read has issued.
  - DRAIN -> IDLE when the last word is popped (valid_o & ready_i).
  - done_o pulses in the cycle after that pop.
- start_i while busy_o=1 is ignored.
- rom_oen_o is low in FETCH and DRAIN and high in IDLE.
- Read issue rule (combinational in FETCH): rom_cen_o=0 iff remaining>0 and fifo_count + inflight < DEPTH.
  - inflight is a one-bit register set on the cycle after an issue.
  - This credit rule makes overflow impossible without inspecting ready_i.
- rom_addr_o is a counter starting at base_addr_i and incremented per issued read. It wraps modulo 2^ADDR_WIDTH (0xFF -> 0x00).
- Capture: when inflight=1, rom_data_i is written into the FIFO that cycle.
- Latency: start_i sampled at edge E0.
  - First rom_cen_o low in cycle 1.
  - Data captured at the end of cycle 2.
  - valid_o high in cycle 3.
- Throughput: one word per cycle while ready_i=1.
- Backpressure: with ready_i=0, issue stops once FIFO plus in-flight entries equal DEPTH, and resumes in the cycle after a pop.
- FIFO semantics: simultaneous push and pop are legal at any occupancy. When empty, valid_o=0 and data_o holds its last value.

Optional Feature:
- Macro: ROM_BURST_RD_LAST_EN.
- When defined, adds output port last_o (1 bit, reset 0), high with valid_o on the final word of the burst. It is carried as an extra FIFO bit.
- When undefined, the port and the FIFO bit do not exist. All other behaviour is identical.

Decomposition:
- Shared defines header holds:
  - state encodings ROM_BRD_IDLE=2'd0, ROM_BRD_FETCH=2'd1, ROM_BRD_DRAIN=2'd2;
  - the default widths.
- One sub-module: rom_burst_rd_fifo, a synchronous FIFO with parameters WIDTH and AW, ports push/pop/count/full/empty, register-array storage.
- Sequencer, counters and credit logic stay in the top module.

Test Plan:
1. base=0x10, len=4, ready_i=1, ROM mem[i]=i*3 -> rom_cen_o low in cycles 1-4 with addr 0x10-0x13. data_o = 0x30, 0x33, 0x36, 0x39 in cycles 3-6. done_o in cycle 7.
2. len=0 -> no rom_cen_o low, done_o pulses in the cycle after start, busy_o stays 0.
3. base=0xFE, len=4 -> addresses 0xFE, 0xFF, 0x00, 0x01 and data in that order.
4. len=8 with ready_i=0 for 10 cycles, then 1 -> exactly 4 reads issue and then stall. No word is lost or duplicated, all 8 words arrive in order, one done_o.
5. rst_n asserted in cycle 3 of a len=16 burst -> all outputs return to reset values immediately. A following burst base=0, len=2 completes normally.
6. With ROM_BURST_RD_LAST_EN, len=3 -> last_o=1 only on the third valid_o beat. Start pulsed while busy -> ignored, with no extra reads.
